nvram_restore: RTL and testbench
================================

# nvram_restore

Restores a hiscore/NVRAM dump, received from the HPS over the ioctl download channel, back into the core's game RAM. It buffers the incoming dump in a local RAM, then pauses the core CPU and writes the dump byte-by-byte into game RAM through a write port. It is the write-back counterpart of the hiscore extract/upload path and uses the same ioctl index and pause handshake. It sits between hps_io and the game-RAM second port in the arcade top level.

## Interface
Parameters:
- DUMPWIDTH, 8: address width of dump buffer and game-RAM port (max 2**DUMPWIDTH bytes)
- DUMPINDEX, 4: ioctl_index carrying the dump
- PAUSEPAD, 4: padding cycles with CPU paused before and after the write burst

Ports:
- clk  in  1  system clock; single clock domain
- reset_n  in  1  synchronous, active-low reset
- paused  in  1  core confirms CPU is paused
- ioctl_download  in  1  HPS download active
- ioctl_wr  in  1  download byte strobe
- ioctl_addr  in  25  download byte address
- ioctl_index  in  8  download index
- ioctl_dout  in  8  download byte
- nvram_address  out  DUMPWIDTH  game-RAM write address
- nvram_data_in  out  8  game-RAM write data
- nvram_we  out  1  game-RAM write enable, one cycle per byte
- pause_cpu  out  1  request CPU pause
- busy  out  1  restore sequence in progress (state != IDLE)
- restored  out  1  sticky: current dump fully written

## Operation
- Capture: downloading = ioctl_download && ioctl_index==DUMPINDEX. On each ioctl_wr while downloading with ioctl_addr < 2**DUMPWIDTH, write ioctl_dout to buffer[ioctl_addr] and set dump_length (DUMPWIDTH+1 bits) to max(dump_length, ioctl_addr+1). Out-of-range addresses are ignored (neither stored nor counted).
- Rising edge of downloading: dump_length<=0, dump_valid<=0, restored<=0. Falling edge: dump_valid<=1 if dump_length!=0.
- The buffer is a single-port synchronous RAM (registered read). During downloading, the ioctl port owns the address; otherwise the FSM owns it.
- FSM states:
  - IDLE: if dump_valid && !restored && !downloading, then pause_cpu<=1 and go to PAUSE.
  - PAUSE: wait for paused==1, then timer<=PAUSEPAD and go to PADIN.
  - PADIN: timer counts down each cycle; at 0, addr<=0 and go to READ.
  - READ: buffer read at addr; nvram_we<=1 and go to WRITE.
  - WRITE: nvram_we high, nvram_address=addr, nvram_data_in=buffer q. nvram_we<=0 on exit. If addr==dump_length-1, timer<=PAUSEPAD and go to PADOUT; else addr<=addr+1 and go to READ.
  - PADOUT: count down; at 0, pause_cpu<=0 and go to DONE.
  - DONE: restored<=1, go to IDLE.
- Abort on new download: if downloading rises in any state other than IDLE, set nvram_we<=0, pause_cpu<=0 and go to IDLE. The new dump re-triggers the sequence once its download ends.
- Reset (reset_n low): state IDLE; pause_cpu, nvram_we, restored, busy all 0; nvram_address 0; nvram_data_in 0. Buffer contents, dump_length and dump_valid are retained, so the restore re-runs after reset release, because game RAM may have been cleared. Power-up initial value of dump_valid is 0.

## Timing
- All outputs are registered. Values after reset: pause_cpu=0, nvram_we=0, busy=0, restored=0, nvram_address=0, nvram_data_in=0.
- pause_cpu rises 1 cycle after the IDLE trigger condition holds.
- If paused is first sampled high at cycle t, the first nvram_we is high at t+PAUSEPAD+3.
- Each byte takes 2 cycles; nvram_we is high 1 cycle in every 2. Address and data are stable during the whole we cycle.
- After the last we cycle, pause_cpu falls PAUSEPAD+2 cycles later. restored rises 1 cycle after that.
- If paused never rises, the FSM stays in PAUSE indefinitely with pause_cpu=1 and no writes.

## Test plan
- Download 16 bytes 0x10..0x1F at addresses 0..15, with paused following pause_cpu by 2 cycles -> 16 nvram_we pulses, addresses 0..15, data 0x10..0x1F, first pulse at t+7 (PAUSEPAD=4), then pause_cpu low, restored=1.
- Same download with paused held 0 -> pause_cpu=1 and busy=1 indefinitely, zero nvram_we pulses. Raise paused -> normal restore completes.
- Download 256 bytes plus a byte at address 300 -> exactly 256 writes, address wraps 0..255, and the address-300 byte never appears.
- Assert reset_n=0 for 3 cycles after the 6th write -> next cycle all outputs 0. After release, the restore reruns from address 0 and all 16 bytes are written.
- Start a new 4-byte download mid-restore -> nvram_we and pause_cpu drop within 1 cycle. After the download ends, only the 4 new bytes are written.
- Download with zero ioctl_wr strobes -> dump_valid stays 0, no pause_cpu, restored=0.

Source files
------------

// File: rtl/nvram_restore.sv
// nvram_restore: buffers an NVRAM/hiscore dump arriving on the ioctl download
// channel, then pauses the core CPU and writes the dump back into game RAM
// one byte every two cycles.
module nvram_restore #(
  parameter int DUMPWIDTH = 8,
  parameter int DUMPINDEX = 4,
  parameter int PAUSEPAD  = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 paused,
  input  logic                 ioctl_download,
  input  logic                 ioctl_wr,
  input  logic [24:0]          ioctl_addr,
  input  logic [7:0]           ioctl_index,
  input  logic [7:0]           ioctl_dout,
  output logic [DUMPWIDTH-1:0] nvram_address,
  output logic [7:0]           nvram_data_in,
  output logic                 nvram_we,
  output logic                 pause_cpu,
  output logic                 busy,
  output logic                 restored
);

  localparam int TW = (PAUSEPAD < 1) ? 1 : $clog2(PAUSEPAD + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PAUSE, S_PADIN, S_READ, S_WRITE, S_PADOUT, S_DONE
  } state_t;

  state_t               state;
  logic [TW-1:0]        timer;
  logic [DUMPWIDTH-1:0] addr;

  // Dump bookkeeping survives reset so a reset re-runs the restore; only the
  // power-up value is defined here.
  logic                 dl_d        = 1'b0;
  logic [DUMPWIDTH:0]   dump_length = '0;
  logic                 dump_valid  = 1'b0;

  logic [7:0]           mem [0:(1 << DUMPWIDTH) - 1];

  logic                 downloading, dl_rise, dl_fall;
  logic                 in_range, cap_we, rd_en, last_byte;
  logic [DUMPWIDTH:0]   cap_len, len_base;
  logic [DUMPWIDTH-1:0] ram_addr;

  assign downloading = ioctl_download && (ioctl_index == 8'(DUMPINDEX));
  assign dl_rise     = downloading && !dl_d;
  assign dl_fall     = !downloading && dl_d;
  assign in_range    = (ioctl_addr >> DUMPWIDTH) == 25'd0;
  assign cap_we      = downloading && ioctl_wr && in_range;
  assign cap_len     = {1'b0, ioctl_addr[DUMPWIDTH-1:0]} + (DUMPWIDTH+1)'(1);
  // A byte landing on the very first download cycle must see a cleared length.
  assign len_base    = dl_rise ? '0 : dump_length;
  // Single RAM port: the ioctl side owns it for the whole download.
  assign ram_addr    = downloading ? ioctl_addr[DUMPWIDTH-1:0] : addr;
  assign rd_en       = (state == S_READ) && !downloading;
  assign last_byte   = ({1'b0, addr} + (DUMPWIDTH+1)'(1)) == dump_length;

  // Track the download window and the highest byte address seen.
  always_ff @(posedge clk) begin
    dl_d <= downloading;
    if (cap_we && (cap_len > len_base)) dump_length <= cap_len;
    else if (dl_rise)                   dump_length <= '0;
    if (dl_rise)      dump_valid <= 1'b0;
    else if (dl_fall) dump_valid <= (dump_length != '0);
  end

  // Dump buffer write port (contents are never reset).
  always_ff @(posedge clk) begin
    if (cap_we) mem[ram_addr] <= ioctl_dout;
  end

  // Registered buffer read; the read register doubles as the game-RAM data.
  always_ff @(posedge clk) begin
    if (!reset_n)   nvram_data_in <= 8'd0;
    else if (rd_en) nvram_data_in <= mem[ram_addr];
  end

  // Restore sequencer: pause, pad, write bytes, pad, release.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      pause_cpu     <= 1'b0;
      nvram_we      <= 1'b0;
      restored      <= 1'b0;
      busy          <= 1'b0;
      nvram_address <= '0;
      timer         <= '0;
      addr          <= '0;
    end else if (dl_rise && state != S_IDLE) begin
      // New dump supersedes the one being written; its end re-triggers us.
      state     <= S_IDLE;
      nvram_we  <= 1'b0;
      pause_cpu <= 1'b0;
      busy      <= 1'b0;
      restored  <= 1'b0;
    end else begin
      if (dl_rise) restored <= 1'b0;
      case (state)
        S_IDLE: begin
          if (dump_valid && !restored && !downloading) begin
            pause_cpu <= 1'b1;
            busy      <= 1'b1;
            state     <= S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (paused) begin
            timer <= TW'(PAUSEPAD);
            state <= S_PADIN;
          end
        end
        S_PADIN: begin
          if (timer == '0) begin
            addr  <= '0;
            state <= S_READ;
          end else timer <= timer - TW'(1);
        end
        S_READ: begin
          nvram_address <= addr;
          nvram_we      <= 1'b1;
          state         <= S_WRITE;
        end
        S_WRITE: begin
          nvram_we <= 1'b0;
          if (last_byte) begin
            timer <= TW'(PAUSEPAD);
            state <= S_PADOUT;
          end else begin
            addr  <= addr + DUMPWIDTH'(1);
            state <= S_READ;
          end
        end
        S_PADOUT: begin
          if (timer == '0) begin
            pause_cpu <= 1'b0;
            state     <= S_DONE;
          end else timer <= timer - TW'(1);
        end
        S_DONE: begin
          restored <= 1'b1;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nvram_restore.sv
// Bench for nvram_restore: table of dumps applied in a loop, scoreboard of
// expected game-RAM writes, and hand sequences for stall, reset and abort.
module tb_nvram_restore;
  localparam int DW  = 8;
  localparam int IDX = 4;
  localparam int PAD = 4;

  logic          clk = 1'b0, reset_n = 1'b0, paused = 1'b0;
  logic          ioctl_download = 1'b0, ioctl_wr = 1'b0;
  logic [24:0]   ioctl_addr = '0;
  logic [7:0]    ioctl_index = '0, ioctl_dout = '0;
  logic [DW-1:0] nvram_address;
  logic [7:0]    nvram_data_in;
  logic          nvram_we, pause_cpu, busy, restored;

  nvram_restore #(.DUMPWIDTH(DW), .DUMPINDEX(IDX), .PAUSEPAD(PAD)) dut (
    .clk(clk), .reset_n(reset_n), .paused(paused),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_index(ioctl_index), .ioctl_dout(ioctl_dout),
    .nvram_address(nvram_address), .nvram_data_in(nvram_data_in),
    .nvram_we(nvram_we), .pause_cpu(pause_cpu), .busy(busy), .restored(restored)
  );

  always #5 clk = ~clk;

  typedef struct { logic [DW-1:0] a; logic [7:0] d; } wr_t;
  typedef struct { int n; int base; int extra; int pd; int exp_writes; } vec_t;

  wr_t  sb[$];
  vec_t vt[4];
  int   checks = 0, failures = 0, cyc = 0;
  int   we_cnt = 0, first_we = -1, last_we = -1, np = -1, pc_fall = -1, rs_rise = -1;
  int   pdly = 1;
  logic hold = 1'b0, prev_we = 1'b0, prev_pc = 1'b0, prev_rs = 1'b0;
  logic [7:0] pc_sh = '0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clr();
    we_cnt = 0; first_we = -1; last_we = -1; np = -1; pc_fall = -1; rs_rise = -1;
  endtask

  // One clock: observe outputs at the falling edge, score writes, drive paused.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (nvram_we) begin
      chk("we_gap", int'(prev_we), 0);
      if (sb.size() == 0) chk("unexpected_write", 1, 0);
      else begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_addr", int'(nvram_address), int'(e.a));
        chk("wr_data", int'(nvram_data_in), int'(e.d));
      end
      we_cnt++;
      if (first_we < 0) first_we = cyc;
      last_we = cyc;
    end
    if (prev_pc && !pause_cpu) pc_fall = cyc;
    if (!prev_rs && restored)  rs_rise = cyc;
    prev_we = nvram_we; prev_pc = pause_cpu; prev_rs = restored;
    pc_sh = {pc_sh[6:0], pause_cpu};
    if (!paused && !hold && pc_sh[pdly] && np < 0) np = cyc;
    paused = !hold && pc_sh[pdly];
  endtask

  task automatic wr_byte(input int a, input int d);
    ioctl_addr = 25'(a); ioctl_dout = 8'(d); ioctl_wr = 1'b1;
    step();
    ioctl_wr = 1'b0;
    step();
  endtask

  task automatic dl(input int n, input int base, input int extra);
    ioctl_index = 8'(IDX); ioctl_download = 1'b1;
    for (int i = 0; i < n; i++) wr_byte(i, base + i);
    if (extra >= 0) wr_byte(extra, 'hFF);
    ioctl_download = 1'b0;
    step();
  endtask

  task automatic push_exp(input int n, input int base);
    for (int i = 0; i < n; i++) sb.push_back('{a: DW'(i), d: 8'(base + i)});
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (!restored && k < budget) begin step(); k++; end
    chk("done_timeout", int'(restored), 1);
  endtask

  task automatic wait_we(input int n, input int budget);
    int k;
    k = 0;
    while (we_cnt < n && k < budget) begin step(); k++; end
    chk("we_timeout", we_cnt, n);
  endtask

  initial begin
    vt[0] = '{16, 'h10, -1, 1, 16};
    vt[1] = '{8,  'h55, -1, 3, 8};
    vt[2] = '{256, 'h00, 300, 1, 256};
    vt[3] = '{1,  'hEE, -1, 0, 1};

    // Reset state
    reset_n = 1'b0;
    repeat (3) step();
    chk("rst_pause_cpu", int'(pause_cpu), 0);
    chk("rst_we", int'(nvram_we), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_restored", int'(restored), 0);
    chk("rst_addr", int'(nvram_address), 0);
    chk("rst_data", int'(nvram_data_in), 0);
    reset_n = 1'b1;
    repeat (5) step();
    chk("no_dump_no_pause", int'(pause_cpu), 0);

    // Table-driven restores
    for (int i = 0; i < 4; i++) begin
      pdly = vt[i].pd;
      repeat (10) step();
      clr();
      dl(vt[i].n, vt[i].base, vt[i].extra);
      push_exp(vt[i].exp_writes, vt[i].base);
      wait_done(3000);
      chk("tbl_writes", we_cnt, vt[i].exp_writes);
      chk("tbl_sb_empty", sb.size(), 0);
      chk("tbl_first_we_lat", first_we - np, PAD + 3);
      chk("tbl_pc_fall_lat", pc_fall - last_we, PAD + 2);
      chk("tbl_restored_lat", rs_rise - last_we, PAD + 3);
      chk("tbl_pause_cpu_low", int'(pause_cpu), 0);
      chk("tbl_busy_low", int'(busy), 0);
    end

    // Paused never rises: stall in PAUSE, then release
    pdly = 1;
    repeat (10) step();
    clr();
    hold = 1'b1;
    dl(16, 'h10, -1);
    push_exp(16, 'h10);
    repeat (200) step();
    chk("stall_pause_cpu", int'(pause_cpu), 1);
    chk("stall_busy", int'(busy), 1);
    chk("stall_no_we", we_cnt, 0);
    hold = 1'b0;
    wait_done(2000);
    chk("stall_writes", we_cnt, 16);
    chk("stall_sb_empty", sb.size(), 0);
    chk("stall_first_we_lat", first_we - np, PAD + 3);

    // Reset after the 6th write: outputs clear, restore reruns in full
    repeat (10) step();
    clr();
    dl(16, 'h30, -1);
    push_exp(16, 'h30);
    wait_we(6, 500);
    reset_n = 1'b0;
    sb.delete();
    push_exp(16, 'h30);
    step();
    chk("mid_rst_pause_cpu", int'(pause_cpu), 0);
    chk("mid_rst_we", int'(nvram_we), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_restored", int'(restored), 0);
    chk("mid_rst_addr", int'(nvram_address), 0);
    chk("mid_rst_data", int'(nvram_data_in), 0);
    repeat (2) step();
    reset_n = 1'b1;
    wait_done(2000);
    chk("rerun_writes", we_cnt, 6 + 16);
    chk("rerun_sb_empty", sb.size(), 0);

    // New download mid-restore aborts; only the new dump is written
    repeat (10) step();
    clr();
    dl(16, 'h40, -1);
    push_exp(16, 'h40);
    wait_we(3, 500);
    ioctl_index = 8'(IDX); ioctl_download = 1'b1;
    sb.delete();
    step();
    chk("abort_we_low", int'(nvram_we), 0);
    chk("abort_pause_low", int'(pause_cpu), 0);
    dl(4, 'hA0, -1);
    push_exp(4, 'hA0);
    wait_done(2000);
    chk("abort_writes", we_cnt, 3 + 4);
    chk("abort_sb_empty", sb.size(), 0);

    // Download with no strobes: nothing to restore
    repeat (10) step();
    clr();
    ioctl_index = 8'(IDX); ioctl_download = 1'b1;
    repeat (3) step();
    ioctl_download = 1'b0;
    repeat (50) step();
    chk("empty_pause_cpu", int'(pause_cpu), 0);
    chk("empty_restored", int'(restored), 0);
    chk("empty_busy", int'(busy), 0);
    chk("empty_no_we", we_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
